rs232rx: RTL and testbench
==========================

# rs232rx

Parametrised, buffered RS-232 receiver: the next-generation serial input for the design. It adds configurable word length, optional parity, 1/2 stop bits, a runtime baud divisor, false-start rejection, framing/parity/break detection and a small receive FIFO with a valid/ready interface. It sits between the asynchronous `serial_in` pin and any consumer (CPU peripheral bus, command decoder) that cannot guarantee to take every byte in the cycle it arrives.

## Interface
- `DATA_BITS`, 8: word length, legal 5..9.
- `FIFO_DEPTH`, 4: receive FIFO entries, power of two, ≥2.
- `DIV_WIDTH`, 16: width of `divisor`.
- `clock`  in  1  sole clock; all logic rises on posedge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `serial_in`  in  1  asynchronous line, idle high.
- `divisor`  in  DIV_WIDTH  clocks per bit; legal ≥4; latched at start-bit detection.
- `parity_en`  in  1  1 = a parity bit follows the data.
- `parity_odd`  in  1  1 = odd parity, 0 = even; ignored when `parity_en`=0.
- `two_stop`  in  1  1 = two stop bits checked.
- `rx_data`  out  DATA_BITS  head-of-FIFO data, LSB = first bit received.
- `rx_parity_err`, `rx_frame_err`, `rx_break`  out  1 each  head-of-FIFO status flags.
- `rx_valid`  out  1  FIFO not empty.
- `rx_ready`  in  1  consumer accepts head entry when `rx_valid & rx_ready`.
- `overrun`  out  1  one-cycle pulse: completed frame dropped because FIFO full.
- `busy`  out  1  receiver not in IDLE.

## Operation
- Reset values: all outputs 0; `rx_data` and flags 0; synchroniser flops reset to 1 (line idle); FSM = IDLE; FIFO empty.
- `serial_in` passes a 2-flop synchroniser; the FSM sees only the synchronised `rxs`.
- Bit counter `cnt` (DIV_WIDTH bits) counts down; a "sample" occurs on the cycle `cnt`==0, which reloads `divisor`-1.
- IDLE: `rxs`=0 → latch `divisor` to `div_q`, `cnt` ← (`div_q`>>1)-1, go START.
- START: at sample, `rxs`=1 → false start, back to IDLE, nothing pushed; `rxs`=0 → DATA, bit index 0.
- DATA: at each sample shift `rxs` in at the MSB of a DATA_BITS shift register (LSB-first on wire); after DATA_BITS samples go PARITY if `parity_en`, else STOP1.
- PARITY: sample; `parity_err` = (XOR of data bits XOR sampled bit) ≠ `parity_odd`.
- STOP1: sample; low → `frame_err`. If `two_stop` go STOP2, else finish. STOP2: sample; low → `frame_err`; finish.
- Break: `break` = all data bits 0, parity bit 0 (if enabled) and STOP1 sample 0. A break always also sets `frame_err`.
- Finish: on the last stop sample cycle push {break, frame_err, parity_err, data}. Next state IDLE if no `frame_err`, else WAIT_HIGH.
- WAIT_HIGH: stay until `rxs`=1, then IDLE. Guarantees one entry per break regardless of break length.
- `parity_odd`, `parity_en`, `two_stop` are sampled live; software changes them only while `busy`=0.
- FIFO: show-ahead; head drives `rx_data`/flags combinationally from storage. Pointers are log2(FIFO_DEPTH)+1 bits, wrapping naturally.
- Push into full FIFO with no pop in the same cycle: entry discarded, `overrun`=1 for that cycle, existing contents unchanged.
- Simultaneous push and pop when full: both happen, no overrun. Simultaneous push and pop when empty: push stored, `rx_valid` rises next cycle.
- Reset mid-frame: FSM to IDLE, FIFO emptied, partial frame lost; no spurious entry after release.

## Timing
- Input latency: 2 cycles through the synchroniser.
- Let cycle T be the first cycle `rxs`=0 in IDLE. START sample at T+`div_q`/2 (integer). Data bit k is sampled at T+`div_q`/2+(k+1)·`div_q`. Later bits follow at one-`div_q` spacing.
- Entry visible (`rx_valid`=1, data on `rx_data`) the cycle after the final stop sample.
- Earliest next start detection is the cycle after the final stop sample, i.e. mid-stop-bit. This tolerates senders up to ~½ bit fast per frame.
- Pop: `rx_valid & rx_ready` at posedge removes the head; next entry (or `rx_valid`=0) visible the following cycle. Full throughput is one pop per cycle.
- `busy` is 1 from cycle T+1 until the cycle after leaving STOP/WAIT_HIGH.

## Test plan
- 8N1, `divisor`=16, send 0xA5 with `rx_ready`=1 → exactly one entry of 0xA5 with all flags 0; `rx_valid` high one cycle after the mid-stop sample, then low.
- 8E1, send 0x03 with parity bit 1 (wrong) → entry 0x03 with `rx_parity_err`=1. Repeat with `parity_odd`=1 → `rx_parity_err`=0.
- `DATA_BITS`=7, `two_stop`=1, second stop bit driven low, data 0x55 → entry 0x55 with `rx_frame_err`=1. FSM waits for line high, then the next frame 0x2A is received clean.
- Glitch: line low 5 clocks at `divisor`=16 → no entry; `busy` pulses then returns to 0. Break: line low 30 bit times → exactly one entry, data 0 with `rx_break`=1 and `rx_frame_err`=1.
- `FIFO_DEPTH`=4, `rx_ready`=0, send 0x01..0x05 → `overrun` pulses once (frame 5). Then `rx_ready`=1 drains 0x01..0x04 in order. Push and pop in the same cycle when full → no overrun.
- Assert `reset` during data bit 3 of a frame with two entries queued → outputs all 0 and FIFO empty. After release, the next 0xC3 frame is received correctly; `divisor` changed mid-frame does not disturb the frame in progress.

Source files
------------

// File: rtl/rs232rx.sv
// rs232rx - buffered RS-232 receiver with runtime baud divisor, optional
// parity, one or two stop bits, false-start rejection, framing/parity/break
// detection and a show-ahead receive FIFO with a valid/ready interface.
//
// Ports:
//   clock          sole clock, rising edge
//   reset          asynchronous active-high reset, clears all state
//   serial_in      asynchronous serial line, idle high
//   divisor        clocks per bit (>= 4), latched at start-bit detection
//   parity_en      1 = a parity bit follows the data bits
//   parity_odd     1 = odd parity, 0 = even parity
//   two_stop       1 = two stop bits are checked
//   rx_data        head-of-FIFO data word, LSB = first bit received
//   rx_parity_err  head-of-FIFO parity error flag
//   rx_frame_err   head-of-FIFO framing error flag
//   rx_break       head-of-FIFO break flag
//   rx_valid       FIFO not empty
//   rx_ready       consumer takes the head entry when rx_valid & rx_ready
//   overrun        one-cycle pulse when a completed frame is dropped (FIFO full)
//   busy           receiver not idle
module rs232rx #(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned DIV_WIDTH  = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 serial_in,
    input  logic [DIV_WIDTH-1:0] divisor,
    input  logic                 parity_en,
    input  logic                 parity_odd,
    input  logic                 two_stop,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_parity_err,
    output logic                 rx_frame_err,
    output logic                 rx_break,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 overrun,
    output logic                 busy
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned EW = DATA_BITS + 3;
    localparam logic [AW:0]           PTR_ONE  = (AW + 1)'(1);
    localparam logic [DIV_WIDTH-1:0]  DIV_ONE  = DIV_WIDTH'(1);
    localparam logic [3:0]            LAST_BIT = 4'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE, START, DATA, PARITY, STOP1, STOP2, WAIT_HIGH
    } state_t;

    state_t               state;
    logic                 sync1, rxs;
    logic [DIV_WIDTH-1:0] div_q, cnt;
    logic [3:0]           bit_idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_err_q, frame_err_q, break_q, par_zero;
    logic                 sample, brk_now;
    logic                 push, pop, full, wr_en;
    logic [EW-1:0]        push_entry, head;
    logic [EW-1:0]        mem [FIFO_DEPTH];
    logic [AW:0]          wr_ptr, rd_ptr;

    // Two-flop synchroniser, reset to the idle (mark) level.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b1;
            rxs   <= 1'b1;
        end else begin
            sync1 <= serial_in;
            rxs   <= sync1;
        end
    end

    assign sample  = (cnt == '0);
    // Break: all data zero, parity bit zero (or absent), first stop bit zero.
    assign brk_now = (shreg == '0) && par_zero && !rxs;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            div_q       <= '0;
            cnt         <= '0;
            bit_idx     <= '0;
            shreg       <= '0;
            par_err_q   <= 1'b0;
            frame_err_q <= 1'b0;
            break_q     <= 1'b0;
            par_zero    <= 1'b1;
        end else begin
            // Free-running down-counter; only meaningful while a frame is active.
            if (sample) cnt <= div_q - DIV_ONE;
            else        cnt <= cnt - DIV_ONE;

            case (state)
                IDLE: begin
                    if (!rxs) begin
                        div_q <= divisor;
                        // First sample lands mid start bit.
                        cnt   <= (divisor >> 1) - DIV_ONE;
                        state <= START;
                    end
                end
                START: begin
                    if (sample) begin
                        if (rxs) begin
                            state <= IDLE;
                        end else begin
                            state       <= DATA;
                            bit_idx     <= '0;
                            par_err_q   <= 1'b0;
                            frame_err_q <= 1'b0;
                            break_q     <= 1'b0;
                            par_zero    <= 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (sample) begin
                        shreg   <= {rxs, shreg[DATA_BITS-1:1]};
                        bit_idx <= bit_idx + 4'd1;
                        if (bit_idx == LAST_BIT)
                            state <= parity_en ? PARITY : STOP1;
                    end
                end
                PARITY: begin
                    if (sample) begin
                        par_err_q <= ((^shreg) ^ rxs) != parity_odd;
                        par_zero  <= ~rxs;
                        state     <= STOP1;
                    end
                end
                STOP1: begin
                    if (sample) begin
                        frame_err_q <= ~rxs;
                        break_q     <= brk_now;
                        if (two_stop)  state <= STOP2;
                        else if (rxs)  state <= IDLE;
                        else           state <= WAIT_HIGH;
                    end
                end
                STOP2: begin
                    if (sample)
                        state <= (frame_err_q || !rxs) ? WAIT_HIGH : IDLE;
                end
                WAIT_HIGH: begin
                    // Holds off re-arming until the line returns to mark,
                    // so a long break yields a single entry.
                    if (rxs) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state != IDLE);

    // Entry is pushed on the final stop-bit sample cycle itself.
    always_comb begin
        push       = 1'b0;
        push_entry = '0;
        if (sample && state == STOP1 && !two_stop) begin
            push       = 1'b1;
            push_entry = {brk_now, ~rxs, par_err_q, shreg};
        end else if (sample && state == STOP2) begin
            push       = 1'b1;
            push_entry = {break_q, frame_err_q | ~rxs, par_err_q, shreg};
        end
    end

    // Show-ahead FIFO with one extra pointer bit to tell full from empty.
    assign rx_valid = (wr_ptr != rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) &&
                      (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop      = rx_valid && rx_ready;
    assign wr_en    = push && (!full || pop);
    assign overrun  = push && full && !pop;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)   rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clock) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= push_entry;
    end

    assign head = rx_valid ? mem[rd_ptr[AW-1:0]] : '0;
    assign {rx_break, rx_frame_err, rx_parity_err, rx_data} = head;

endmodule

// File: tb/tb_rs232rx.sv
// tb_rs232rx - self-checking bench for rs232rx: an 8-bit and a 7-bit
// receiver are driven with serial frames; expected FIFO entries come from a
// frame-level reference model of the received word and status flags.
module tb_rs232rx;

    logic        clock = 1'b0;
    logic        reset;
    logic        line8, line7;
    logic [15:0] divisor;
    logic        parity_en, parity_odd, two_stop;
    logic        rx_ready8, rx_ready7;
    logic [7:0]  rx_data8;
    logic        pe8, fe8, brk8, valid8, ovr8, busy8;
    logic [6:0]  rx_data7;
    logic        pe7, fe7, brk7, valid7, ovr7, busy7;

    int checks = 0;
    int failures = 0;
    int ovr_count = 0;

    typedef struct packed {
        logic       brk;
        logic       fe;
        logic       pe;
        logic [8:0] data;
    } exp_t;

    rs232rx #(.DATA_BITS(8), .FIFO_DEPTH(4), .DIV_WIDTH(16)) dut8 (
        .clock(clock), .reset(reset), .serial_in(line8), .divisor(divisor),
        .parity_en(parity_en), .parity_odd(parity_odd), .two_stop(two_stop),
        .rx_data(rx_data8), .rx_parity_err(pe8), .rx_frame_err(fe8),
        .rx_break(brk8), .rx_valid(valid8), .rx_ready(rx_ready8),
        .overrun(ovr8), .busy(busy8)
    );

    rs232rx #(.DATA_BITS(7), .FIFO_DEPTH(4), .DIV_WIDTH(16)) dut7 (
        .clock(clock), .reset(reset), .serial_in(line7), .divisor(divisor),
        .parity_en(parity_en), .parity_odd(parity_odd), .two_stop(two_stop),
        .rx_data(rx_data7), .rx_parity_err(pe7), .rx_frame_err(fe7),
        .rx_break(brk7), .rx_valid(valid7), .rx_ready(rx_ready7),
        .overrun(ovr7), .busy(busy7)
    );

    always #5 clock = ~clock;

    always @(negedge clock) if (ovr8) ovr_count++;

    // Reference model: what a receiver must report for one transmitted frame.
    function automatic exp_t model(input logic [8:0] data, input int nbits,
                                   input logic pen, input logic podd,
                                   input logic pbit, input logic s1,
                                   input logic s2, input logic two);
        exp_t e;
        int ones;
        logic [8:0] d;
        ones = 0;
        d = '0;
        for (int i = 0; i < nbits; i++) begin
            d[i] = data[i];
            ones += int'(data[i]);
        end
        e.data = d;
        e.pe   = pen && (((ones + int'(pbit)) % 2) != int'(podd));
        e.fe   = !s1 || (two && !s2);
        e.brk  = (d == '0) && (!pen || !pbit) && !s1;
        return e;
    endfunction

    function automatic exp_t head8();
        return exp_t'({brk8, fe8, pe8, 1'b0, rx_data8});
    endfunction

    function automatic exp_t head7();
        return exp_t'({brk7, fe7, pe7, 2'b00, rx_data7});
    endfunction

    task automatic idle(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic set_line(input bit to7, input logic v);
        if (to7) line7 = v;
        else     line8 = v;
    endtask

    // Bit j of the frame (start = 0) is driven just after the (j*d)-th posedge.
    task automatic send_frame(input bit to7, input logic [8:0] data,
                              input int nbits, input logic pen,
                              input logic pbit, input logic s1, input logic s2,
                              input int nstop, input int d);
        @(posedge clock); #1;
        set_line(to7, 1'b0); idle(d);
        for (int k = 0; k < nbits; k++) begin
            set_line(to7, data[k]); idle(d);
        end
        if (pen) begin
            set_line(to7, pbit); idle(d);
        end
        set_line(to7, s1); idle(d);
        if (nstop == 2) begin
            set_line(to7, s2); idle(d);
        end
        set_line(to7, 1'b1);
    endtask

    task automatic pop(input bit to7);
        @(posedge clock); #1;
        if (to7) rx_ready7 = 1'b1;
        else     rx_ready8 = 1'b1;
        @(posedge clock); #1;
        rx_ready7 = 1'b0;
        rx_ready8 = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        checks++;
        if ({valid8, busy8, ovr8, brk8, fe8, pe8, rx_data8} !== 14'h0) begin
            failures++;
            $display("FAIL reset_out8: actual=%0h required=0",
                     {valid8, busy8, ovr8, brk8, fe8, pe8, rx_data8});
        end
        checks++;
        if ({valid7, busy7, ovr7, brk7, fe7, pe7, rx_data7} !== 13'h0) begin
            failures++;
            $display("FAIL reset_out7: actual=%0h required=0",
                     {valid7, busy7, ovr7, brk7, fe7, pe7, rx_data7});
        end
        @(posedge clock); #1;
        reset = 1'b0;
        idle(4);
        @(negedge clock);
        checks++;
        if ({valid8, busy8} !== 2'b00) begin
            failures++;
            $display("FAIL reset_release: actual=%0b required=00", {valid8, busy8});
        end
    endtask

    task automatic test_basic;
        int d;
        int l;
        exp_t e;
        d = 16;
        l = 9;
        divisor = 16'(d); parity_en = 1'b0; two_stop = 1'b0; rx_ready8 = 1'b1;
        e = model(9'h0A5, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        fork
            send_frame(1'b0, 9'h0A5, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1, d);
            begin
                @(posedge clock);
                repeat (2) @(posedge clock);
                @(negedge clock);
                checks++;
                if (busy8 !== 1'b0) begin
                    failures++;
                    $display("FAIL basic_busy_T: actual=%0b required=0", busy8);
                end
                @(posedge clock);
                @(negedge clock);
                checks++;
                if (busy8 !== 1'b1) begin
                    failures++;
                    $display("FAIL basic_busy_T1: actual=%0b required=1", busy8);
                end
                repeat (d / 2 + l * d - 1) @(posedge clock);
                @(negedge clock);
                checks++;
                if (valid8 !== 1'b0) begin
                    failures++;
                    $display("FAIL basic_valid_early: actual=%0b required=0", valid8);
                end
                @(posedge clock);
                @(negedge clock);
                checks++;
                if (valid8 !== 1'b1) begin
                    failures++;
                    $display("FAIL basic_valid: actual=%0b required=1", valid8);
                end
                checks++;
                if (head8() !== e) begin
                    failures++;
                    $display("FAIL basic_entry: actual=%0h required=%0h", head8(), e);
                end
                @(negedge clock);
                checks++;
                if (valid8 !== 1'b0) begin
                    failures++;
                    $display("FAIL basic_drained: actual=%0b required=0", valid8);
                end
            end
        join
        rx_ready8 = 1'b0;
        idle(4);
    endtask

    task automatic test_parity;
        exp_t e0, e1;
        divisor = 16'd12; parity_en = 1'b1; parity_odd = 1'b0; two_stop = 1'b0;
        rx_ready8 = 1'b0;
        send_frame(1'b0, 9'h003, 8, 1'b1, 1'b1, 1'b1, 1'b1, 1, 12);
        e0 = model(9'h003, 8, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        idle(4);
        parity_odd = 1'b1;
        send_frame(1'b0, 9'h003, 8, 1'b1, 1'b1, 1'b1, 1'b1, 1, 12);
        e1 = model(9'h003, 8, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        idle(2);
        @(negedge clock);
        checks++;
        if (head8() !== e0 || valid8 !== 1'b1) begin
            failures++;
            $display("FAIL parity_even: actual=%0h/%0b required=%0h/1", head8(), valid8, e0);
        end
        pop(1'b0);
        @(negedge clock);
        checks++;
        if (head8() !== e1 || valid8 !== 1'b1) begin
            failures++;
            $display("FAIL parity_odd: actual=%0h/%0b required=%0h/1", head8(), valid8, e1);
        end
        pop(1'b0);
        @(negedge clock);
        checks++;
        if (valid8 !== 1'b0) begin
            failures++;
            $display("FAIL parity_drained: actual=%0b required=0", valid8);
        end
        parity_en = 1'b0; parity_odd = 1'b0;
    endtask

    task automatic test_frame7;
        exp_t e0, e1;
        divisor = 16'd16; parity_en = 1'b0; two_stop = 1'b1; rx_ready7 = 1'b0;
        send_frame(1'b1, 9'h055, 7, 1'b0, 1'b0, 1'b1, 1'b0, 2, 16);
        e0 = model(9'h055, 7, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        idle(4);
        @(negedge clock);
        checks++;
        if (busy7 !== 1'b0) begin
            failures++;
            $display("FAIL frame7_idle: actual=%0b required=0", busy7);
        end
        send_frame(1'b1, 9'h02A, 7, 1'b0, 1'b0, 1'b1, 1'b1, 2, 16);
        e1 = model(9'h02A, 7, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        idle(2);
        @(negedge clock);
        checks++;
        if (head7() !== e0 || valid7 !== 1'b1) begin
            failures++;
            $display("FAIL frame7_err: actual=%0h/%0b required=%0h/1", head7(), valid7, e0);
        end
        pop(1'b1);
        @(negedge clock);
        checks++;
        if (head7() !== e1 || valid7 !== 1'b1) begin
            failures++;
            $display("FAIL frame7_clean: actual=%0h/%0b required=%0h/1", head7(), valid7, e1);
        end
        pop(1'b1);
        @(negedge clock);
        checks++;
        if (valid7 !== 1'b0) begin
            failures++;
            $display("FAIL frame7_drained: actual=%0b required=0", valid7);
        end
        two_stop = 1'b0;
    endtask

    task automatic test_glitch_break;
        logic busy_seen;
        exp_t e;
        divisor = 16'd16; parity_en = 1'b0; two_stop = 1'b0; rx_ready8 = 1'b0;
        busy_seen = 1'b0;
        @(negedge clock);
        line8 = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clock);
            if (i == 4) line8 = 1'b1;
            if (busy8) busy_seen = 1'b1;
        end
        checks++;
        if ({busy_seen, busy8, valid8} !== 3'b100) begin
            failures++;
            $display("FAIL glitch: actual=%0b required=100 (seen,busy,valid)",
                     {busy_seen, busy8, valid8});
        end
        @(posedge clock); #1;
        line8 = 1'b0;
        idle(30 * 16);
        line8 = 1'b1;
        idle(3 * 16);
        e = model(9'h000, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clock);
        checks++;
        if (head8() !== e || valid8 !== 1'b1) begin
            failures++;
            $display("FAIL break_entry: actual=%0h/%0b required=%0h/1", head8(), valid8, e);
        end
        pop(1'b0);
        @(negedge clock);
        checks++;
        if ({valid8, busy8} !== 2'b00) begin
            failures++;
            $display("FAIL break_single: actual=%0b required=00", {valid8, busy8});
        end
    endtask

    task automatic test_overrun;
        int d;
        int base;
        exp_t e;
        d = 8;
        divisor = 16'(d); parity_en = 1'b0; two_stop = 1'b0; rx_ready8 = 1'b0;
        base = ovr_count;
        for (int i = 1; i <= 4; i++)
            send_frame(1'b0, 9'(i), 8, 1'b0, 1'b0, 1'b1, 1'b1, 1, d);
        idle(2);
        checks++;
        if (ovr_count - base != 0) begin
            failures++;
            $display("FAIL overrun_none: actual=%0d required=0", ovr_count - base);
        end
        send_frame(1'b0, 9'h005, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1, d);
        idle(2);
        checks++;
        if (ovr_count - base != 1) begin
            failures++;
            $display("FAIL overrun_once: actual=%0d required=1", ovr_count - base);
        end
        for (int i = 1; i <= 4; i++) begin
            e = model(9'(i), 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
            @(negedge clock);
            checks++;
            if (head8() !== e || valid8 !== 1'b1) begin
                failures++;
                $display("FAIL overrun_drain%0d: actual=%0h/%0b required=%0h/1",
                         i, head8(), valid8, e);
            end
            pop(1'b0);
        end
        @(negedge clock);
        checks++;
        if (valid8 !== 1'b0) begin
            failures++;
            $display("FAIL overrun_empty: actual=%0b required=0", valid8);
        end
        // Fill, then pop in exactly the cycle frame 0x15 is pushed.
        for (int i = 1; i <= 4; i++)
            send_frame(1'b0, 9'(16 + i), 8, 1'b0, 1'b0, 1'b1, 1'b1, 1, d);
        base = ovr_count;
        fork
            send_frame(1'b0, 9'h015, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1, d);
            begin
                @(posedge clock);
                repeat (2 + d / 2 + 9 * d) @(posedge clock);
                #1 rx_ready8 = 1'b1;
                @(posedge clock);
                #1 rx_ready8 = 1'b0;
            end
        join
        idle(2);
        checks++;
        if (ovr_count - base != 0) begin
            failures++;
            $display("FAIL pushpop_full: actual=%0d required=0", ovr_count - base);
        end
        for (int i = 2; i <= 5; i++) begin
            e = model(9'(16 + i), 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
            @(negedge clock);
            checks++;
            if (head8() !== e || valid8 !== 1'b1) begin
                failures++;
                $display("FAIL pushpop_drain%0d: actual=%0h/%0b required=%0h/1",
                         i, head8(), valid8, e);
            end
            pop(1'b0);
        end
    endtask

    task automatic test_random;
        exp_t q[$];
        logic [8:0] data;
        logic pbit, s1, s2;
        int d;
        int n;
        for (int b = 0; b < 4; b++) begin
            parity_en  = 1'($urandom_range(0, 1));
            parity_odd = 1'($urandom_range(0, 1));
            two_stop   = 1'($urandom_range(0, 1));
            d = int'($urandom_range(4, 24));
            divisor = 16'(d);
            n = int'($urandom_range(1, 4));
            q.delete();
            for (int f = 0; f < n; f++) begin
                data = 9'($urandom_range(0, 255));
                pbit = 1'($urandom_range(0, 1));
                s1   = ($urandom_range(0, 4) != 0);
                s2   = ($urandom_range(0, 4) != 0);
                if ($urandom_range(0, 7) == 0) begin
                    data = '0;
                    s1 = 1'b0;
                end
                send_frame(1'b0, data, 8, parity_en, pbit, s1, s2,
                           two_stop ? 2 : 1, d);
                q.push_back(model(data, 8, parity_en, parity_odd, pbit, s1, s2, two_stop));
                idle(4);
            end
            for (int i = 0; i < n; i++) begin
                @(negedge clock);
                checks++;
                if (head8() !== q[i] || valid8 !== 1'b1) begin
                    failures++;
                    $display("FAIL random_b%0d_f%0d: actual=%0h/%0b required=%0h/1",
                             b, i, head8(), valid8, q[i]);
                end
                pop(1'b0);
            end
            @(negedge clock);
            checks++;
            if (valid8 !== 1'b0) begin
                failures++;
                $display("FAIL random_b%0d_empty: actual=%0b required=0", b, valid8);
            end
        end
        parity_en = 1'b0; parity_odd = 1'b0; two_stop = 1'b0;
    endtask

    task automatic test_reset_mid;
        int d;
        logic [8:0] data;
        exp_t e;
        d = 16;
        divisor = 16'(d); parity_en = 1'b0; two_stop = 1'b0; rx_ready8 = 1'b0;
        for (int i = 0; i < 2; i++)
            send_frame(1'b0, 9'($urandom_range(0, 255)), 8, 1'b0, 1'b0, 1'b1, 1'b1, 1, d);
        idle(2);
        @(negedge clock);
        checks++;
        if (valid8 !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_queued: actual=%0b required=1", valid8);
        end
        // Upper data bits are 1 so the line stays at mark once reset releases.
        data = {1'b0, 4'hF, 4'($urandom_range(0, 15))};
        fork
            send_frame(1'b0, data, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1, d);
            begin
                @(posedge clock);
                repeat (4 * d + d / 2) @(posedge clock);
                #1 reset = 1'b1;
                @(negedge clock);
                checks++;
                if ({valid8, busy8, ovr8, brk8, fe8, pe8, rx_data8} !== 14'h0) begin
                    failures++;
                    $display("FAIL rstmid_out: actual=%0h required=0",
                             {valid8, busy8, ovr8, brk8, fe8, pe8, rx_data8});
                end
                repeat (d) @(posedge clock);
                #1 reset = 1'b0;
            end
        join
        idle(3 * d);
        @(negedge clock);
        checks++;
        if ({valid8, busy8} !== 2'b00) begin
            failures++;
            $display("FAIL rstmid_spurious: actual=%0b required=00", {valid8, busy8});
        end
        e = model(9'h0C3, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        fork
            send_frame(1'b0, 9'h0C3, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1, d);
            begin
                idle(3 * d);
                divisor = 16'd7;
            end
        join
        idle(2);
        @(negedge clock);
        checks++;
        if (head8() !== e || valid8 !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_c3: actual=%0h/%0b required=%0h/1", head8(), valid8, e);
        end
        pop(1'b0);
        @(negedge clock);
        checks++;
        if (valid8 !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_empty: actual=%0b required=0", valid8);
        end
        divisor = 16'd16;
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset      = 1'b1;
        line8      = 1'b1;
        line7      = 1'b1;
        divisor    = 16'd16;
        parity_en  = 1'b0;
        parity_odd = 1'b0;
        two_stop   = 1'b0;
        rx_ready8  = 1'b0;
        rx_ready7  = 1'b0;
        test_reset();
        test_basic();
        test_parity();
        test_frame7();
        test_glitch_break();
        test_overrun();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
